// File: rtl/bram_arb_pkg.sv
// Shared definitions for the two-requester BRAM port arbiter.
// Holds the requester id type, arbitration-mode encodings and the read-latency helper.
// No logic; imported by bram_port_arbiter and bram_arb_tag_pipe.
package bram_arb_pkg;

   // One bit is enough to name either of the two requesters
   localparam int REQ_ID_W = 1;

   typedef logic [REQ_ID_W-1:0] req_id_t;

   localparam req_id_t REQ0 = 1'b0;
   localparam req_id_t REQ1 = 1'b1;

   // Arbitration policies selectable through the ARB_MODE parameter
   typedef enum logic {
      ARB_RR    = 1'b0,
      ARB_FIXED = 1'b1
   } arb_mode_e;

   // BRAM read latency in cycles: one for the array, one more with the output register
   function automatic int lat_of(input int pipelined);
      return 1 + pipelined;
   endfunction

endpackage

// File: rtl/bram_arb_tag_pipe.sv
// Tracks accepted BRAM accesses as {valid, requester id} through the read latency.
// Latency: LAT cycles from the grant edge to the output stage.
// No backpressure: one entry enters per cycle and leaves LAT cycles later; async clear drops all entries.
module bram_arb_tag_pipe
   import bram_arb_pkg::*;
#(
   parameter int LAT = 1
)
(
   input  logic    clk,
   input  logic    rst_n,
   input  logic    in_vld,
   input  req_id_t in_id,
   output logic    out_vld,
   output req_id_t out_id
);

   logic [LAT-1:0] vld_q;
   logic [LAT-1:0] vld_d;
   req_id_t        id_q [LAT];
   req_id_t        id_d [LAT];

   // Shift every stage forward by one; stage 0 captures this cycle's grant
   always_comb begin
      vld_d    = '0;
      id_d     = '{default: REQ0};
      vld_d[0] = in_vld;
      id_d[0]  = in_id;
      for (int i = 1; i < LAT; i++) begin
         vld_d[i] = vld_q[i-1];
         id_d[i]  = id_q[i-1];
      end
   end

   // Stage registers; reset discards every access still in flight
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < LAT; i++) begin
            id_q[i] <= REQ0;
         end
      end else begin
         vld_q <= vld_d;
         for (int i = 0; i < LAT; i++) begin
            id_q[i] <= id_d[i];
         end
      end
   end

   assign out_vld = vld_q[LAT-1];
   assign out_id  = id_q[LAT-1];

endmodule

// File: rtl/bram_port_arbiter.sv
// Shares one write-first BRAM port between req0 (core) and req1 (debug/loader); optional grant counters under BRAM_ARB_STATS_EN.
// Latency: grant and BRAM drive in the request cycle; tagged response 1+PIPELINED cycles after the grant edge.
// Backpressure: valid/ready on requests only; responses are single-cycle strobes the requester must sink.
module bram_port_arbiter
   import bram_arb_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int PIPELINED  = 0,
   parameter int ARB_MODE   = 0
)
(
   input  logic                  clk,
   input  logic                  rst_n,

   input  logic                  req0_valid,
   output logic                  req0_ready,
   input  logic                  req0_we,
   input  logic [ADDR_WIDTH-1:0] req0_addr,
   input  logic [DATA_WIDTH-1:0] req0_wdata,

   input  logic                  req1_valid,
   output logic                  req1_ready,
   input  logic                  req1_we,
   input  logic [ADDR_WIDTH-1:0] req1_addr,
   input  logic [DATA_WIDTH-1:0] req1_wdata,

   output logic                  rsp0_valid,
   output logic [DATA_WIDTH-1:0] rsp0_rdata,
   output logic                  rsp1_valid,
   output logic [DATA_WIDTH-1:0] rsp1_rdata,

   output logic                  bram_en,
   output logic                  bram_we,
   output logic [ADDR_WIDTH-1:0] bram_addr,
   output logic [DATA_WIDTH-1:0] bram_wdata,
   input  logic [DATA_WIDTH-1:0] bram_rdata
`ifdef BRAM_ARB_STATS_EN
   ,
   input  logic                  stat_clr,
   output logic [31:0]           stat0_grants,
   output logic [31:0]           stat1_grants
`endif
);

   localparam int LAT = lat_of(PIPELINED);

   // Requester granted most recently; drives round-robin alternation
   req_id_t last_q;
   req_id_t last_d;

   // Address/data last presented to the BRAM, held through idle cycles
   logic [ADDR_WIDTH-1:0] addr_hold_q;
   logic [ADDR_WIDTH-1:0] addr_hold_d;
   logic [DATA_WIDTH-1:0] wdata_hold_q;
   logic [DATA_WIDTH-1:0] wdata_hold_d;

   logic    gnt_vld;
   req_id_t gnt_id;
   logic    rsp_vld;
   req_id_t rsp_id;

   // Pick this cycle's winner; nothing is granted while reset is asserted
   always_comb begin
      gnt_vld = 1'b0;
      gnt_id  = REQ0;
      if (rst_n) begin
         if (req0_valid && req1_valid) begin
            gnt_vld = 1'b1;
            if (ARB_MODE == int'(ARB_FIXED)) begin
               gnt_id = REQ0;
            end else begin
               gnt_id = (last_q == REQ0) ? REQ1 : REQ0;
            end
         end else if (req0_valid) begin
            gnt_vld = 1'b1;
            gnt_id  = REQ0;
         end else if (req1_valid) begin
            gnt_vld = 1'b1;
            gnt_id  = REQ1;
         end
      end
   end

   assign req0_ready = gnt_vld && (gnt_id == REQ0);
   assign req1_ready = gnt_vld && (gnt_id == REQ1);

   // Next pointer and hold values move only when a transfer is accepted
   always_comb begin
      last_d       = last_q;
      addr_hold_d  = addr_hold_q;
      wdata_hold_d = wdata_hold_q;
      if (gnt_vld) begin
         last_d       = gnt_id;
         addr_hold_d  = (gnt_id == REQ1) ? req1_addr  : req0_addr;
         wdata_hold_d = (gnt_id == REQ1) ? req1_wdata : req0_wdata;
      end
   end

   // Pointer starts as if req1 went last so req0 wins the first contested cycle
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         last_q       <= REQ1;
         addr_hold_q  <= '0;
         wdata_hold_q <= '0;
      end else begin
         last_q       <= last_d;
         addr_hold_q  <= addr_hold_d;
         wdata_hold_q <= wdata_hold_d;
      end
   end

   // Drive the BRAM port from the winner in the grant cycle; enable only on a real grant
   always_comb begin
      bram_en    = gnt_vld;
      bram_we    = 1'b0;
      bram_addr  = addr_hold_q;
      bram_wdata = wdata_hold_q;
      if (gnt_vld) begin
         bram_we    = (gnt_id == REQ1) ? req1_we    : req0_we;
         bram_addr  = (gnt_id == REQ1) ? req1_addr  : req0_addr;
         bram_wdata = (gnt_id == REQ1) ? req1_wdata : req0_wdata;
      end
   end

   bram_arb_tag_pipe #(
      .LAT (LAT)
   ) u_tag_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .in_vld  (gnt_vld),
      .in_id   (gnt_id),
      .out_vld (rsp_vld),
      .out_id  (rsp_id)
   );

   // Steer the BRAM output to whichever requester owns the access now leaving the pipe
   always_comb begin
      rsp0_valid = rsp_vld && (rsp_id == REQ0);
      rsp1_valid = rsp_vld && (rsp_id == REQ1);
      rsp0_rdata = rsp0_valid ? bram_rdata : '0;
      rsp1_rdata = rsp1_valid ? bram_rdata : '0;
   end

`ifdef BRAM_ARB_STATS_EN
   logic [31:0] stat0_q;
   logic [31:0] stat0_d;
   logic [31:0] stat1_q;
   logic [31:0] stat1_d;

   // Saturating per-requester grant counts; a clear beats a grant in the same cycle
   always_comb begin
      stat0_d = stat0_q;
      stat1_d = stat1_q;
      if (stat_clr) begin
         stat0_d = '0;
         stat1_d = '0;
      end else begin
         if (req0_ready && (stat0_q != 32'hFFFF_FFFF)) begin
            stat0_d = stat0_q + 32'd1;
         end
         if (req1_ready && (stat1_q != 32'hFFFF_FFFF)) begin
            stat1_d = stat1_q + 32'd1;
         end
      end
   end

   // Counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stat0_q <= '0;
         stat1_q <= '0;
      end else begin
         stat0_q <= stat0_d;
         stat1_q <= stat1_d;
      end
   end

   assign stat0_grants = stat0_q;
   assign stat1_grants = stat1_q;
`endif

endmodule

// File: tb/tb_bram_port_arbiter.sv
// Bench: three arbiters (RR/L=1, fixed/L=1, RR/L=2) share one stimulus, each with its own write-first BRAM.
// A cycle-level scoreboard predicts grants, BRAM drive and responses; literal checks pin key scenarios.
// Counter checks are compiled in when BRAM_ARB_STATS_EN is defined.
module tb_bram_port_arbiter;

   localparam int AW = 8;
   localparam int DW = 32;
   localparam int NI = 3;
   localparam int LOGN = 512;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          req0_valid, req0_we, req1_valid, req1_we;
   logic [AW-1:0] req0_addr, req1_addr;
   logic [DW-1:0] req0_wdata, req1_wdata;

   logic          r0_rdy [NI];
   logic          r1_rdy [NI];
   logic          s0_v   [NI];
   logic          s1_v   [NI];
   logic [DW-1:0] s0_d   [NI];
   logic [DW-1:0] s1_d   [NI];
   logic          b_en   [NI];
   logic          b_we   [NI];
   logic [AW-1:0] b_ad   [NI];
   logic [DW-1:0] b_wd   [NI];
   logic [DW-1:0] b_rd   [NI];
`ifdef BRAM_ARB_STATS_EN
   logic          stat_clr;
   logic [31:0]   st0 [NI];
   logic [31:0]   st1 [NI];
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < NI; g++) begin : g_dut
      localparam int AM = (g == 1) ? 1 : 0;
      localparam int PL = (g == 2) ? 1 : 0;
      logic [DW-1:0] mem [256];
      logic [DW-1:0] do1;
      logic [DW-1:0] do2;

      bram_port_arbiter #(
         .ADDR_WIDTH (AW),
         .DATA_WIDTH (DW),
         .PIPELINED  (PL),
         .ARB_MODE   (AM)
      ) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .req0_valid (req0_valid),
         .req0_ready (r0_rdy[g]),
         .req0_we    (req0_we),
         .req0_addr  (req0_addr),
         .req0_wdata (req0_wdata),
         .req1_valid (req1_valid),
         .req1_ready (r1_rdy[g]),
         .req1_we    (req1_we),
         .req1_addr  (req1_addr),
         .req1_wdata (req1_wdata),
         .rsp0_valid (s0_v[g]),
         .rsp0_rdata (s0_d[g]),
         .rsp1_valid (s1_v[g]),
         .rsp1_rdata (s1_d[g]),
         .bram_en    (b_en[g]),
         .bram_we    (b_we[g]),
         .bram_addr  (b_ad[g]),
         .bram_wdata (b_wd[g]),
         .bram_rdata (b_rd[g])
`ifdef BRAM_ARB_STATS_EN
         ,
         .stat_clr     (stat_clr),
         .stat0_grants (st0[g]),
         .stat1_grants (st1[g])
`endif
      );

      initial begin
         for (int i = 0; i < 256; i++) mem[i] = '0;
      end

      // Write-first BRAM with optional output register (register always clocked)
      always @(posedge clk) begin
         if (b_en[g]) begin
            if (b_we[g]) begin
               mem[b_ad[g]] <= b_wd[g];
               do1          <= b_wd[g];
            end else begin
               do1 <= mem[b_ad[g]];
            end
         end
         do2 <= do1;
      end
      assign b_rd[g] = (PL != 0) ? do2 : do1;
   end

   function automatic int am_of(input int g);
      return (g == 1) ? 1 : 0;
   endfunction

   function automatic int lat_model(input int g);
      return (g == 2) ? 2 : 1;
   endfunction

   task automatic chk(input string nm, input int g, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s inst%0d: got %0h expected %0h", nm, g, act, exp);
      end
   endtask

   // Scoreboard state: expected responses indexed by the cycle they are due
   int            cyc = 0;
   bit            mlast [NI];
   logic [AW-1:0] maddr [NI];
   logic [DW-1:0] mwd   [NI];
   logic [DW-1:0] mmem  [NI][256];
   bit            ev    [NI][4];
   bit            eid   [NI][4];
   logic [DW-1:0] ed    [NI][4];

   // Observed grants and responses, for the literal scenario checks
   int            glog_n [NI];
   int            glog_c [NI][LOGN];
   bit            glog_i [NI][LOGN];
   int            rlog_n [NI];
   int            rlog_c [NI][LOGN];
   bit            rlog_i [NI][LOGN];
   logic [DW-1:0] rlog_d [NI][LOGN];

   initial begin
      for (int g = 0; g < NI; g++) begin
         for (int a = 0; a < 256; a++) mmem[g][a] = '0;
         for (int s = 0; s < 4; s++) ev[g][s] = 1'b0;
         mlast[g]  = 1'b1;
         maddr[g]  = '0;
         mwd[g]    = '0;
         glog_n[g] = 0;
         rlog_n[g] = 0;
      end
   end

   // Per-cycle comparison of every instance against the scoreboard
   always @(negedge clk) begin
      for (int g = 0; g < NI; g++) begin
         bit            gv, gid, wr;
         int            slot;
         logic [AW-1:0] a;
         logic [DW-1:0] wd, d;
         if (r0_rdy[g] === 1'b1 && glog_n[g] < LOGN) begin
            glog_c[g][glog_n[g]] = cyc; glog_i[g][glog_n[g]] = 1'b0; glog_n[g]++;
         end
         if (r1_rdy[g] === 1'b1 && glog_n[g] < LOGN) begin
            glog_c[g][glog_n[g]] = cyc; glog_i[g][glog_n[g]] = 1'b1; glog_n[g]++;
         end
         if (s0_v[g] === 1'b1 && rlog_n[g] < LOGN) begin
            rlog_c[g][rlog_n[g]] = cyc; rlog_i[g][rlog_n[g]] = 1'b0;
            rlog_d[g][rlog_n[g]] = s0_d[g]; rlog_n[g]++;
         end
         if (s1_v[g] === 1'b1 && rlog_n[g] < LOGN) begin
            rlog_c[g][rlog_n[g]] = cyc; rlog_i[g][rlog_n[g]] = 1'b1;
            rlog_d[g][rlog_n[g]] = s1_d[g]; rlog_n[g]++;
         end
         if (!rst_n) begin
            chk("rst_ready0", g, 64'(r0_rdy[g]), 64'd0);
            chk("rst_ready1", g, 64'(r1_rdy[g]), 64'd0);
            chk("rst_bram_en", g, 64'(b_en[g]), 64'd0);
            chk("rst_bram_we", g, 64'(b_we[g]), 64'd0);
            chk("rst_bram_addr", g, 64'(b_ad[g]), 64'd0);
            chk("rst_bram_wdata", g, 64'(b_wd[g]), 64'd0);
            chk("rst_rsp_valid", g, 64'({s0_v[g], s1_v[g]}), 64'd0);
            chk("rst_rsp_data", g, 64'(s0_d[g] | s1_d[g]), 64'd0);
            for (int s = 0; s < 4; s++) ev[g][s] = 1'b0;
            mlast[g] = 1'b1;
            maddr[g] = '0;
            mwd[g]   = '0;
         end else begin
            gv = req0_valid || req1_valid;
            if (req0_valid && req1_valid) gid = (am_of(g) == 1) ? 1'b0 : !mlast[g];
            else                          gid = req1_valid;
            wr = gid ? req1_we    : req0_we;
            a  = gid ? req1_addr  : req0_addr;
            wd = gid ? req1_wdata : req0_wdata;
            chk("ready0", g, 64'(r0_rdy[g]), 64'(gv && !gid));
            chk("ready1", g, 64'(r1_rdy[g]), 64'(gv && gid));
            chk("bram_en", g, 64'(b_en[g]), 64'(gv));
            if (gv) begin
               chk("bram_we", g, 64'(b_we[g]), 64'(wr));
               chk("bram_addr", g, 64'(b_ad[g]), 64'(a));
               chk("bram_wdata", g, 64'(b_wd[g]), 64'(wd));
            end else begin
               chk("bram_addr_hold", g, 64'(b_ad[g]), 64'(maddr[g]));
               chk("bram_wdata_hold", g, 64'(b_wd[g]), 64'(mwd[g]));
            end
            slot = cyc % 4;
            if (ev[g][slot]) begin
               chk("rsp_valid", g, 64'({s1_v[g], s0_v[g]}), eid[g][slot] ? 64'd2 : 64'd1);
               chk("rsp_data", g, eid[g][slot] ? 64'(s1_d[g]) : 64'(s0_d[g]), 64'(ed[g][slot]));
            end else begin
               chk("rsp_idle", g, 64'({s1_v[g], s0_v[g]}), 64'd0);
            end
            ev[g][slot] = 1'b0;
            if (gv) begin
               d = wr ? wd : mmem[g][a];
               if (wr) mmem[g][a] = wd;
               slot = (cyc + lat_model(g)) % 4;
               ev[g][slot]  = 1'b1;
               eid[g][slot] = gid;
               ed[g][slot]  = d;
               mlast[g] = gid;
               maddr[g] = a;
               mwd[g]   = wd;
            end
         end
      end
      cyc++;
   end

   task automatic idle();
      req0_valid = 1'b0; req0_we = 1'b0;
      req1_valid = 1'b0; req1_we = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
      #1;
   endtask

   int gb [NI];
   int rb [NI];

   task automatic mark();
      for (int g = 0; g < NI; g++) begin
         gb[g] = glog_n[g];
         rb[g] = rlog_n[g];
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [5:0] got;
      rst_n = 1'b1;
      idle();
      req0_addr = 8'd7; req0_wdata = '0;
      req1_addr = 8'd9; req1_wdata = '0;
`ifdef BRAM_ARB_STATS_EN
      stat_clr = 1'b0;
`endif
      #2 rst_n = 1'b0;

      // 1: reset with both valid, then req0 wins first
      req0_valid = 1'b1; req1_valid = 1'b1;
      at_neg();
      at_neg();
      chk("t1_rst_ready0", 0, 64'(r0_rdy[0]), 64'd0);
      chk("t1_rst_ready1", 0, 64'(r1_rdy[0]), 64'd0);
      chk("t1_rst_en", 0, 64'(b_en[0]), 64'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      at_neg();
      for (int g = 0; g < NI; g++) begin
         chk("t1_first_ready0", g, 64'(r0_rdy[g]), 64'd1);
         chk("t1_first_ready1", g, 64'(r1_rdy[g]), 64'd0);
      end
      @(posedge clk); #1;
      idle();
      step(4);

      // 2: req0 write then read of addr 5 (L=1 instance)
      mark();
      req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 8'd5; req0_wdata = 32'hDEADBEEF;
      step(1);
      req0_we = 1'b0;
      step(1);
      idle();
      step(4);
      chk("t2_n_grants", 0, 64'(glog_n[0] - gb[0]), 64'd2);
      chk("t2_n_rsp", 0, 64'(rlog_n[0] - rb[0]), 64'd2);
      for (int k = 0; k < 2; k++) begin
         chk("t2_rsp_id", 0, 64'(rlog_i[0][rb[0]+k]), 64'd0);
         chk("t2_rsp_data", 0, 64'(rlog_d[0][rb[0]+k]), 64'hDEADBEEF);
         chk("t2_rsp_lat", 0, 64'(rlog_c[0][rb[0]+k] - glog_c[0][gb[0]+k]), 64'd1);
      end

      // 3: both valid for six cycles from a fresh reset
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      mark();
      req0_valid = 1'b1; req0_addr = 8'd1;
      req1_valid = 1'b1; req1_addr = 8'd2;
      step(6);
      idle();
      step(4);
      for (int g = 0; g < NI; g++) begin
         chk("t3_n_grants", g, 64'(glog_n[g] - gb[g]), 64'd6);
         got = '0;
         for (int k = 0; k < 6; k++) got[k] = glog_i[g][gb[g]+k];
         chk("t3_grant_order", g, 64'(got), (g == 1) ? 64'b000000 : 64'b101010);
      end

      // 4: req1 writes then four back-to-back reads of addr 0..3 (L=2 instance)
      for (int k = 0; k < 4; k++) begin
         req1_valid = 1'b1; req1_we = 1'b1;
         req1_addr = 8'(k); req1_wdata = 32'hA000_0000 + 32'(k);
         step(1);
      end
      idle();
      step(4);
      mark();
      for (int k = 0; k < 4; k++) begin
         req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 8'(k);
         step(1);
      end
      idle();
      step(6);
      chk("t4_n_rsp", 2, 64'(rlog_n[2] - rb[2]), 64'd4);
      for (int k = 0; k < 4; k++) begin
         chk("t4_rsp_id", 2, 64'(rlog_i[2][rb[2]+k]), 64'd1);
         chk("t4_rsp_data", 2, 64'(rlog_d[2][rb[2]+k]), 64'hA000_0000 + 64'(k));
         chk("t4_rsp_cycle", 2, 64'(rlog_c[2][rb[2]+k] - glog_c[2][gb[2]]), 64'(2 + k));
      end

      // 5: reset one cycle after a read grant drops its response (L=2 instance)
      mark();
      req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 8'd5;
      step(1);
      idle();
      rst_n = 1'b0;
      step(3);
      rst_n = 1'b1;
      step(5);
      chk("t5_grant_seen", 2, 64'(glog_n[2] - gb[2]), 64'd1);
      chk("t5_no_rsp", 2, 64'(rlog_n[2] - rb[2]), 64'd0);

      // Write from step 2 survives resets
      mark();
      req0_valid = 1'b1; req0_addr = 8'd5;
      step(1);
      idle();
      step(4);
      chk("t5_mem_kept_n", 2, 64'(rlog_n[2] - rb[2]), 64'd1);
      chk("t5_mem_kept", 2, 64'(rlog_d[2][rb[2]]), 64'hDEADBEEF);

`ifdef BRAM_ARB_STATS_EN
      // 6: grant counters, and clear winning over a same-cycle grant
      rst_n = 1'b0;
      step(2);
      rst_n = 1'b1;
      req0_valid = 1'b1; req0_addr = 8'd3;
      step(10);
      idle();
      req1_valid = 1'b1; req1_addr = 8'd4;
      step(3);
      idle();
      at_neg();
      for (int g = 0; g < 2; g++) begin
         chk("t6_stat0", g, 64'(st0[g]), 64'd10);
         chk("t6_stat1", g, 64'(st1[g]), 64'd3);
      end
      @(posedge clk); #1;
      stat_clr = 1'b1; req0_valid = 1'b1;
      step(1);
      stat_clr = 1'b0; idle();
      at_neg();
      chk("t6_clr_stat0", 0, 64'(st0[0]), 64'd0);
      chk("t6_clr_stat1", 0, 64'(st1[0]), 64'd0);
      @(posedge clk); #1;
      req1_valid = 1'b1;
      step(1);
      idle();
      at_neg();
      chk("t6_after_clr_stat1", 0, 64'(st1[0]), 64'd1);
      @(posedge clk); #1;
`endif

      step(3);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
